// File: rtl/tile_blitter_if.sv
// tile_blitter_if: request/pixel port bundle between a tile requester (master) and tile_blitter (slave).
interface tile_blitter_if #(
  parameter int TILE_W = 4,
  parameter int TILE_H = 4,
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int C_W    = 3
);
  logic                     go;
  logic [X_W-1:0]           x_in;
  logic [Y_W-1:0]           y_in;
  logic [C_W-1:0]           fg_colour;
  logic [C_W-1:0]           bg_colour;
  logic                     transparent;
  logic [TILE_W*TILE_H-1:0] mask;
  logic [X_W-1:0]           x;
  logic [Y_W-1:0]           y;
  logic [C_W-1:0]           c;
  logic                     writeEn;
  logic                     busy;
  logic                     done;
  modport master (output go, x_in, y_in, fg_colour, bg_colour, transparent, mask,
                  input x, y, c, writeEn, busy, done);
  modport slave  (input go, x_in, y_in, fg_colour, bg_colour, transparent, mask,
                  output x, y, c, writeEn, busy, done);
endinterface

// File: rtl/tile_blitter.sv
// tile_blitter: latches a masked TILE_WxTILE_H tile on go and streams one registered pixel per cycle.
// Define TILE_BLITTER_CLIP_EN to suppress writes of pixels outside SCREEN_W x SCREEN_H.
module tile_blitter #(
  parameter int TILE_W   = 4,
  parameter int TILE_H   = 4,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int C_W      = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input logic            CLOCK_50,
  input logic            reset,
  tile_blitter_if.slave  bus
);
  localparam int N  = TILE_W * TILE_H;
  localparam int KW = N > 1 ? $clog2(N) : 1;
  localparam int CW = TILE_W > 1 ? $clog2(TILE_W) : 1;
  localparam int RW = TILE_H > 1 ? $clog2(TILE_H) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAW, S_FLUSH, S_DONE} state_t;
  state_t r_state, w_next;

  logic [KW-1:0]  r_k;
  logic [CW-1:0]  r_col;
  logic [RW-1:0]  r_row;
  logic [X_W-1:0] r_x_org, r_x;
  logic [Y_W-1:0] r_y_org, r_y;
  logic [C_W-1:0] r_fg, r_bg, r_c;
  logic [N-1:0]   r_mask;
  logic           r_tr, r_we;
  logic           w_bit, w_paint, w_vis, w_last;

`ifdef TILE_BLITTER_CLIP_EN
  logic [X_W:0] w_x;
  logic [Y_W:0] w_y;
  assign w_x   = {1'b0, r_x_org} + (X_W+1)'(r_col);
  assign w_y   = {1'b0, r_y_org} + (Y_W+1)'(r_row);
  assign w_vis = w_x < (X_W+1)'(SCREEN_W) && w_y < (Y_W+1)'(SCREEN_H);
`else
  logic [X_W-1:0] w_x;
  logic [Y_W-1:0] w_y;
  assign w_x   = r_x_org + X_W'(r_col);
  assign w_y   = r_y_org + Y_W'(r_row);
  assign w_vis = SCREEN_W > 0 && SCREEN_H > 0;
`endif

  assign w_bit   = r_mask[r_k];
  assign w_paint = w_bit | ~r_tr;
  assign w_last  = r_k == KW'(N - 1);

  assign bus.x       = r_x;
  assign bus.y       = r_y;
  assign bus.c       = r_c;
  assign bus.writeEn = r_we;
  assign bus.busy    = r_state != S_IDLE;
  assign bus.done    = r_state == S_DONE;

  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;

  always_comb begin
    w_next = r_state == S_IDLE  ? (bus.go ? S_LOAD : S_IDLE) :
             r_state == S_LOAD  ? S_DRAW :
             r_state == S_DRAW  ? (w_last ? S_FLUSH : S_DRAW) :
             r_state == S_FLUSH ? S_DONE : S_IDLE;
  end

  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      r_k     <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_x_org <= '0;
      r_y_org <= '0;
      r_fg    <= '0;
      r_bg    <= '0;
      r_tr    <= 1'b0;
      r_mask  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_c     <= '0;
      r_we    <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (r_state == S_LOAD) begin
        r_x_org <= bus.x_in;
        r_y_org <= bus.y_in;
        r_fg    <= bus.fg_colour;
        r_bg    <= bus.bg_colour;
        r_tr    <= bus.transparent;
        r_mask  <= bus.mask;
        r_k     <= '0;
        r_col   <= '0;
        r_row   <= '0;
      end else if (r_state == S_DRAW) begin
        r_x   <= w_x[X_W-1:0];
        r_y   <= w_y[Y_W-1:0];
        r_we  <= w_vis & w_paint;
        if (w_paint) r_c <= w_bit ? r_fg : r_bg;
        r_k   <= r_k + 1'b1;
        r_col <= r_col == CW'(TILE_W - 1) ? '0 : r_col + 1'b1;
        if (r_col == CW'(TILE_W - 1)) r_row <= r_row + 1'b1;
      end
    end
endmodule

// File: tb/tb_tile_blitter.sv
// tb_tile_blitter: drives a 4x4 and an 8x2 blitter against a row-major pixel model of each job.
module tb_tile_blitter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tile_blitter_if #(.TILE_W(4), .TILE_H(4)) b0 ();
  tile_blitter_if #(.TILE_W(8), .TILE_H(2)) b1 ();
  tile_blitter #(.TILE_W(4), .TILE_H(4)) d0 (.CLOCK_50(clk), .reset(rst), .bus(b0.slave));
  tile_blitter #(.TILE_W(8), .TILE_H(2)) d1 (.CLOCK_50(clk), .reset(rst), .bus(b1.slave));

`ifdef TILE_BLITTER_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] cur_x [2];
  logic [6:0] cur_y [2];
  logic [2:0] cur_c [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_go(input int sel, input logic v);
    if (sel != 0) b1.go = v; else b0.go = v;
  endtask

  task automatic set_in(input logic [7:0] x, input logic [6:0] y, input logic [2:0] fg,
                        input logic [2:0] bg, input logic tr, input logic [15:0] m);
    b0.x_in = x; b0.y_in = y; b0.fg_colour = fg; b0.bg_colour = bg; b0.transparent = tr; b0.mask = m;
    b1.x_in = x; b1.y_in = y; b1.fg_colour = fg; b1.bg_colour = bg; b1.transparent = tr; b1.mask = m;
  endtask

  task automatic check_out(input int sel, input string tag, input logic we, input logic busy, input logic done);
    chk({tag, " x"},    sel != 0 ? 32'(b1.x) : 32'(b0.x), 32'(cur_x[sel]));
    chk({tag, " y"},    sel != 0 ? 32'(b1.y) : 32'(b0.y), 32'(cur_y[sel]));
    chk({tag, " c"},    sel != 0 ? 32'(b1.c) : 32'(b0.c), 32'(cur_c[sel]));
    chk({tag, " we"},   sel != 0 ? 32'(b1.writeEn) : 32'(b0.writeEn), 32'(we));
    chk({tag, " busy"}, sel != 0 ? 32'(b1.busy) : 32'(b0.busy), 32'(busy));
    chk({tag, " done"}, sel != 0 ? 32'(b1.done) : 32'(b0.done), 32'(done));
  endtask

  // One full job: the expected pixel stream is built from row/column loops, then checked per cycle.
  task automatic run_job(input int sel, input logic [7:0] x, input logic [6:0] y, input logic [2:0] fg,
                         input logic [2:0] bg, input logic tr, input logic [15:0] m, input bit midgo);
    int w, h, k, xf, yf;
    logic [7:0] ex [16];
    logic [6:0] ey [16];
    logic [2:0] ec [16];
    logic       ew [16];
    logic [2:0] nc;
    w = sel != 0 ? 8 : 4;
    h = sel != 0 ? 2 : 4;
    nc = cur_c[sel];
    for (int r = 0; r < h; r++)
      for (int q = 0; q < w; q++) begin
        k = r * w + q;
        xf = int'(x) + q;
        yf = int'(y) + r;
        ex[k] = xf[7:0];
        ey[k] = yf[6:0];
        ew[k] = (m[k] || !tr) && (!CLIP || (xf < 160 && yf < 120));
        if (m[k] || !tr) nc = m[k] ? fg : bg;
        ec[k] = nc;
      end
    set_in(x, y, fg, bg, tr, m);
    @(negedge clk);
    set_go(sel, 1'b1);
    @(posedge clk);
    #1 set_go(sel, 1'b0);
    for (int e = 0; e < 20; e++) begin
      if (e > 0) begin
        @(posedge clk);
        #1;
      end
      k = e - 2;
      if (k >= 0 && k < 16) begin
        cur_x[sel] = ex[k];
        cur_y[sel] = ey[k];
        cur_c[sel] = ec[k];
      end
      check_out(sel, $sformatf("j%0d e%0d", sel, e), (k >= 0 && k < 16) ? ew[k] : 1'b0, e <= 18, e == 18);
      if (midgo && e == 5) set_go(sel, 1'b1);
      if (midgo && e == 6) set_go(sel, 1'b0);
    end
    if (midgo) begin
      @(posedge clk);
      #1 chk("midgo ignored busy", sel != 0 ? 32'(b1.busy) : 32'(b0.busy), 32'd0);
    end
  endtask

  initial begin
    int t1, t2, nd, nw;
    b0.go = 1'b0;
    b1.go = 1'b0;
    set_in('0, '0, '0, '0, 1'b0, '0);
    for (int s = 0; s < 2; s++) begin
      cur_x[s] = '0; cur_y[s] = '0; cur_c[s] = '0;
    end
    #1;
    check_out(0, "reset0", 1'b0, 1'b0, 1'b0);
    check_out(1, "reset1", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    run_job(0, 8'd10, 7'd20, 3'b100, 3'b001, 1'b0, 16'h9009, 1'b0);
    run_job(0, 8'd10, 7'd20, 3'b100, 3'b001, 1'b1, 16'h9009, 1'b0);
    run_job(1, 8'd254, 7'd5, 3'd7, 3'd2, 1'b0, 16'hFFFF, 1'b0);
    run_job(1, 8'd158, 7'd118, 3'd3, 3'd6, 1'b0, 16'hFFFF, 1'b0);
    run_job(0, 8'd253, 7'd126, 3'd5, 3'd1, 1'b0, 16'h3C5A, 1'b0);

    for (int i = 0; i < 8; i++) begin
      automatic logic [7:0]  rx = 8'($urandom);
      automatic logic [6:0]  ry = 7'($urandom);
      automatic logic [2:0]  rf = 3'($urandom);
      automatic logic [2:0]  rb = 3'($urandom);
      automatic logic        rt = 1'($urandom);
      automatic logic [15:0] rm = 16'($urandom);
      run_job(i % 2, rx, ry, rf, rb, rt, rm, i == 2 || i == 5);
    end

    set_in(8'd30, 7'd40, 3'd6, 3'd2, 1'b0, 16'hA5C3);
    @(negedge clk);
    b0.go = 1'b1;
    @(posedge clk);
    #1 b0.go = 1'b0;
    repeat (7) @(posedge clk);
    #1 chk("pre-reset we", 32'(b0.writeEn), 32'd1);
    #1 rst = 1'b1;
    #1;
    for (int s = 0; s < 2; s++) begin
      cur_x[s] = '0; cur_y[s] = '0; cur_c[s] = '0;
    end
    check_out(0, "async reset", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check_out(0, $sformatf("in reset %0d", i), 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    run_job(0, 8'd30, 7'd40, 3'd6, 3'd2, 1'b0, 16'hA5C3, 1'b0);

    set_in(8'd50, 7'd60, 3'd5, 3'd3, 1'b0, 16'hFFFF);
    t1 = -1; t2 = -1; nd = 0; nw = 0;
    @(negedge clk);
    b0.go = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(posedge clk);
      #1;
      if (t == 39) b0.go = 1'b0;
      if (b0.writeEn === 1'b1) nw++;
      if (b0.done === 1'b1) begin
        nd++;
        if (t1 < 0) t1 = t; else if (t2 < 0) t2 = t;
      end
    end
    chk("held go done count", 32'(nd), 32'd2);
    chk("held go first done", 32'(t1), 32'd18);
    chk("held go done spacing", 32'(t2 - t1), 32'd20);
    chk("held go writes", 32'(nw), 32'd32);
    chk("held go idle after", 32'(b0.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
